// File: rtl/eq_out_pkg.sv
// Shared definitions for the equaliser output stage: Q2.14 unity, ramp states
// and the 16-bit saturation helpers.
package eq_out_pkg;

    localparam int Q14_ONE = 16384;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_UNMUTED   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_RAMP_UP   = 2'd3
    } ramp_state_e;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767)
            return 16'sh7FFF;
        else if (x < -32'sd32768)
            return 16'sh8000;
        return x[15:0];
    endfunction

    function automatic logic sat16_hit(input logic signed [31:0] x);
        return (x > 32'sd32767) || (x < -32'sd32768);
    endfunction

endpackage

// File: rtl/sat_mul_q14.sv
// Registered Q2.14 multiply: y = sat16((a * b) >>> 14), with a saturation flag
// aligned to the registered result.
module sat_mul_q14
    import eq_out_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic signed [15:0] a_i,
    input  logic signed [15:0] b_i,
    output logic signed [15:0] y_o,
    output logic               sat_o
);

    logic signed [31:0] prod;
    logic signed [31:0] shifted;
    logic signed [15:0] y_d, y_q;
    logic               sat_d, sat_q;

    // Arithmetic shift floors toward minus infinity.
    assign prod    = 32'(a_i) * 32'(b_i);
    assign shifted = prod >>> 14;
    assign y_d     = sat16(shifted);
    assign sat_d   = sat16_hit(shifted);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/output_stage.sv
// Audio output stage: master gain, soft-mute ramp and saturation, producing one
// DAC word per I2S frame, four cycles after the synchronised word-select edge.
module output_stage
    import eq_out_pkg::*;
#(
    parameter int RAMP_STEP   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic               lmmi_clk_i,
    input  logic               reset_n_i,
    input  logic               ws_i,
    input  logic signed [15:0] audio_i,
    input  logic signed [15:0] gain_i,
    input  logic               mute_i,
    output logic [31:0]        dac_data_o,
    output logic               sample_valid_o,
    output logic               clip_o,
    output logic               muted_o
);

    localparam logic [15:0] STEP16 = 16'(RAMP_STEP);
    localparam logic [15:0] ONE16  = 16'(Q14_ONE);

    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES:0]   ws_shift;
    logic                   ws_hist_q;
    logic                   evt;

    ramp_state_e state_q, state_d;
    logic [14:0] ramp_q, ramp_d;
    logic [15:0] up_sum;
    logic        muted_q;

    logic signed [15:0] audio_p0_q, gain_p0_q;
    logic [14:0]        ramp_p0_q, ramp_p1_q;
    logic               vld_p0_q, vld_p1_q, vld_p2_q;
    logic signed [15:0] ramp_s_p1;
    logic signed [15:0] s1_p1, s2_p2;
    logic               sat1_p1, sat2_p2, sat1_p2_q;

    logic [31:0] dac_q;
    logic        valid_q, clip_q;

    assign ws_shift = {ws_sync_q, ws_i};
    assign evt      = ws_shift[SYNC_STAGES] & ~ws_hist_q;

    // Synchroniser and history preset high so ws_i held high through reset
    // release cannot look like a rising edge.
    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ws_sync_q <= '1;
            ws_hist_q <= 1'b1;
        end else begin
            ws_sync_q <= ws_shift[SYNC_STAGES-1:0];
            ws_hist_q <= ws_shift[SYNC_STAGES];
        end
    end

    always_comb begin
        ramp_d  = ramp_q;
        state_d = state_q;
        up_sum  = {1'b0, ramp_q} + STEP16;
        if (evt) begin
            if (mute_i)
                ramp_d = ({1'b0, ramp_q} > STEP16) ? 15'({1'b0, ramp_q} - STEP16) : '0;
            else
                ramp_d = (up_sum >= ONE16) ? 15'(ONE16) : up_sum[14:0];

            if (ramp_d == '0)
                state_d = ST_MUTED;
            else if ({1'b0, ramp_d} == ONE16)
                state_d = ST_UNMUTED;
            else if (mute_i)
                state_d = ST_RAMP_DOWN;
            else
                state_d = ST_RAMP_UP;
        end
    end

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_MUTED;
            ramp_q  <= '0;
            muted_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
            muted_q <= (state_q == ST_MUTED);
        end
    end

    // p0: capture the frame's operands and the ramp in force at the event.
    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            audio_p0_q <= '0;
            gain_p0_q  <= '0;
            ramp_p0_q  <= '0;
            vld_p0_q   <= 1'b0;
        end else begin
            vld_p0_q <= evt;
            if (evt) begin
                audio_p0_q <= audio_i;
                gain_p0_q  <= gain_i;
                ramp_p0_q  <= ramp_q;
            end
        end
    end

    // p1: master gain.
    sat_mul_q14 u_gain (
        .clk_i  (lmmi_clk_i),
        .rst_ni (reset_n_i),
        .a_i    (audio_p0_q),
        .b_i    (gain_p0_q),
        .y_o    (s1_p1),
        .sat_o  (sat1_p1)
    );

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ramp_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            ramp_p1_q <= ramp_p0_q;
            vld_p1_q  <= vld_p0_q;
        end
    end

    // p2: mute ramp; ramp is unsigned so it is zero-extended into the signed multiplier.
    assign ramp_s_p1 = {1'b0, ramp_p1_q};

    sat_mul_q14 u_ramp (
        .clk_i  (lmmi_clk_i),
        .rst_ni (reset_n_i),
        .a_i    (s1_p1),
        .b_i    (ramp_s_p1),
        .y_o    (s2_p2),
        .sat_o  (sat2_p2)
    );

    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sat1_p2_q <= 1'b0;
            vld_p2_q  <= 1'b0;
        end else begin
            sat1_p2_q <= sat1_p1;
            vld_p2_q  <= vld_p1_q;
        end
    end

    // p3: DAC word register, held between frames.
    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dac_q   <= '0;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            valid_q <= vld_p2_q;
            clip_q  <= vld_p2_q & (sat1_p2_q | sat2_p2);
            if (vld_p2_q)
                dac_q <= {8'h00, s2_p2, 8'h00};
        end
    end

    assign dac_data_o     = dac_q;
    assign sample_valid_o = valid_q;
    assign clip_o         = clip_q;
    assign muted_o        = muted_q;

endmodule

// File: tb/tb_output_stage.sv
// Self-checking bench for output_stage: directed and random frames compared
// against an arithmetic model of gain, mute ramp and saturation.
module tb_output_stage;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ws;
    logic signed [15:0] audio;
    logic signed [15:0] gain;
    logic               mute;
    logic [31:0]        dac;
    logic               valid;
    logic               clip;
    logic               muted;

    int checks = 0;
    int errors = 0;
    int ramp_m = 0;

    output_stage #(.RAMP_STEP(256), .SYNC_STAGES(2)) dut (
        .lmmi_clk_i     (clk),
        .reset_n_i      (reset_n),
        .ws_i           (ws),
        .audio_i        (audio),
        .gain_i         (gain),
        .mute_i         (mute),
        .dac_data_o     (dac),
        .sample_valid_o (valid),
        .clip_o         (clip),
        .muted_o        (muted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_q14(input longint p);
        longint q;
        q = p / 16384;
        if (p < 0 && q * 16384 != p)
            q = q - 1;
        return q;
    endfunction

    // Reference: two saturating Q2.14 products, then ramp steps toward its target.
    task automatic model(input int a, input int g, input bit m, output int s, output bit c);
        longint v1, v2;
        c  = 1'b0;
        v1 = floor_q14(longint'(a) * longint'(g));
        if (v1 > 32767)  begin v1 = 32767;  c = 1'b1; end
        if (v1 < -32768) begin v1 = -32768; c = 1'b1; end
        v2 = floor_q14(v1 * longint'(ramp_m));
        if (v2 > 32767)  begin v2 = 32767;  c = 1'b1; end
        if (v2 < -32768) begin v2 = -32768; c = 1'b1; end
        s = int'(v2);
        if (m) ramp_m = (ramp_m > 256) ? ramp_m - 256 : 0;
        else   ramp_m = (ramp_m + 256 > 16384) ? 16384 : ramp_m + 256;
    endtask

    // Called just after a rising edge with ws low and settled.
    task automatic frame(input int a, input int g, input bit m);
        int          es;
        bit          ec;
        logic        em;
        logic [15:0] s16;
        model(a, g, m, es, ec);
        em  = (ramp_m == 0);
        s16 = 16'(es);
        ws    = 1'b1;
        audio = 16'(a);
        gain  = 16'(g);
        mute  = m;
        repeat (3) @(posedge clk);
        #1;
        audio = 16'($urandom);
        gain  = 16'($urandom);
        repeat (2) @(posedge clk);
        #1 chk("valid_early", {31'd0, valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("valid_e4", {31'd0, valid}, 32'd1);
        chk("dac", dac, {8'h00, s16, 8'h00});
        chk("clip", {31'd0, clip}, {31'd0, ec});
        ws = 1'b0;
        @(posedge clk);
        #1 chk("valid_pulse_end", {31'd0, valid | clip}, 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("muted", {31'd0, muted}, {31'd0, em});
    endtask

    initial begin
        int          npulse;
        logic [15:0] rv;

        reset_n = 1'b0;
        ws      = 1'b1;
        audio   = '0;
        gain    = '0;
        mute    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dac", dac, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_clip", {31'd0, clip}, 32'd0);
        chk("rst_muted", {31'd0, muted}, 32'd1);

        // Release with ws high: no event expected.
        reset_n = 1'b1;
        npulse  = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (valid) npulse++;
        end
        chk("no_spurious_evt", 32'(npulse), 32'd0);
        ws = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Unmute ramp from reset: sample k equals the ramp used, 256*(k-1).
        for (int k = 1; k <= 65; k++) begin
            frame(16384, 16384, 1'b0);
            rv = 16'(256 * (k - 1));
            chk("ramp_up_sample", dac, {8'h00, rv, 8'h00});
            if (k == 1) chk("muted_fall_evt1", {31'd0, muted}, 32'd0);
        end

        frame(1000, 16384, 1'b0);
        chk("unity_1000", dac, 32'h0003E800);
        frame(30000, 32767, 1'b0);
        chk("sat_pos", dac, 32'h007FFF00);
        frame(-32768, 16384, 1'b0);
        chk("neg_full", dac, 32'h00800000);

        for (int i = 0; i < 20; i++)
            frame(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768, 1'b0);

        // Mute fully, climb to 4096, then reverse.
        for (int i = 0; i < 64; i++) frame(16384, 16384, 1'b1);
        chk("muted_after_down", {31'd0, muted}, 32'd1);
        for (int i = 0; i < 16; i++) frame(16384, 16384, 1'b0);
        for (int k = 0; k <= 16; k++) begin
            frame(16384, 16384, 1'b1);
            rv = 16'(4096 - 256 * k);
            chk("reverse_sample", dac, {8'h00, rv, 8'h00});
        end
        chk("muted_after_reverse", {31'd0, muted}, 32'd1);

        for (int i = 0; i < 30; i++)
            frame(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                  ($urandom_range(3) == 0));
        for (int i = 0; i < 4; i++) frame(1000, 16384, 1'b0);

        // Reset at E+2 must drop the in-flight sample.
        ws    = 1'b1;
        audio = 16'sd1000;
        gain  = 16'sd16384;
        mute  = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_dac", dac, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_clip", {31'd0, clip}, 32'd0);
        chk("midrst_muted", {31'd0, muted}, 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (valid) npulse++;
        end
        chk("midrst_no_pulse", 32'(npulse), 32'd0);
        chk("midrst_dac_hold", dac, 32'd0);
        chk("midrst_muted_hold", {31'd0, muted}, 32'd1);
        ramp_m = 0;
        ws = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        frame(16384, 16384, 1'b0);
        frame(16384, 16384, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
